fir_mc_engine: RTL and testbench



---
 rtl/fir_mc_engine.sv | 201 ++++++++++++++++++++
 tb/tb_fir_mc_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mc_engine.sv
// fir_mc_engine: multi-channel FIR multiply-accumulate engine.
// One request runs NUM_TAPS MACs on NUM_CH channels in parallel, all channels
// sharing one coefficient stream read from an external ROM. The result is
// arithmetic-shifted by SHIFT, saturated to DATA_W and published with a
// one-cycle done pulse.
//
// Optional feature macro: FIR_MC_ROUND_EN
//   defined   : add 2^(SHIFT-1) before the shift (round half toward +inf)
//   undefined : plain truncating arithmetic shift
//
// Handshake: start is sampled only in IDLE; busy is high whenever the engine is
// not IDLE. The ROM and sample queue each return data exactly one cycle after
// coef_addr / smpl_rd are presented; there is no back-pressure on either.
//
// Pass timeline (start sampled at edge E):
//   edges E+1..E+NUM_TAPS   : present taps 0..NUM_TAPS-1 (smpl_rd high NUM_TAPS cycles)
//   edges E+3..E+NUM_TAPS+2 : accumulate returned products (last one leaves DRAIN)
//   edge  E+NUM_TAPS+3      : leave DONE, register smpl_out/sat, raise done
module fir_mc_engine #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 1021,
  parameter int NUM_CH   = 2,
  parameter int ACC_W    = 42,
  parameter int SHIFT    = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clr,
  output logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  output logic                       smpl_rd,
  input  logic [COEF_W-1:0]          coeff_in,
  input  logic [NUM_CH*DATA_W-1:0]   smpl_in,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH*DATA_W-1:0]   smpl_out,
  output logic [NUM_CH-1:0]          sat
);

  localparam int AW     = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);

  // Saturation limits and rounding constant, one bit wider than the
  // accumulator so the rounding add can never wrap.
  localparam logic signed [ACC_W:0] Y_MAX =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] Y_MIN =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};
`ifdef FIR_MC_ROUND_EN
  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
`else
  localparam logic signed [ACC_W:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             tap_q, tap_d;
  logic [AW-1:0]             coef_addr_q, coef_addr_d;
  logic                      smpl_rd_q, smpl_rd_d;
  logic                      valid_d1_q;
  logic                      done_q, done_d;
  logic [NUM_CH*DATA_W-1:0]  smpl_out_q, smpl_out_d;
  logic [NUM_CH-1:0]         sat_q, sat_d;
  logic signed [ACC_W-1:0]   acc_q [NUM_CH];
  logic signed [ACC_W-1:0]   acc_d [NUM_CH];

  logic                      start_pass;
  logic                      publish;
  logic                      last_issued;
  logic signed [PROD_W-1:0]  prod   [NUM_CH];
  logic signed [ACC_W:0]     rnd    [NUM_CH];
  logic signed [ACC_W:0]     shaped [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]  y_clip;
  logic [NUM_CH-1:0]         y_sat;

  // The final address is on the bus this cycle; nothing more to issue.
  assign last_issued = smpl_rd_q && (coef_addr_q == LAST_TAP);

  // Next-state and tap sequencing; RUN stays until the last address has been presented.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    coef_addr_d = coef_addr_q;
    smpl_rd_d   = 1'b0;
    start_pass  = 1'b0;
    publish     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!clr && start) begin
          state_d    = S_RUN;
          tap_d      = '0;
          start_pass = 1'b1;
        end
      end
      S_RUN: begin
        if (clr) begin
          state_d = S_IDLE;
        end else if (last_issued) begin
          state_d = S_DRAIN;
        end else begin
          smpl_rd_d   = 1'b1;
          coef_addr_d = tap_q;
          if (tap_q != LAST_TAP) tap_d = tap_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = clr ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        publish = !clr;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-channel MAC: cleared on pass start, accumulates while returned data is valid.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      prod[c]  = $signed(coeff_in) * $signed(smpl_in[c*DATA_W +: DATA_W]);
      acc_d[c] = acc_q[c];
      if (start_pass) begin
        acc_d[c] = '0;
      end else if (valid_d1_q) begin
        acc_d[c] = acc_q[c] + ACC_W'(prod[c]);
      end
    end
  end

  // Output shaping: optional rounding, arithmetic shift, clip to DATA_W.
  always_comb begin
    y_clip = '0;
    y_sat  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rnd[c]    = (ACC_W + 1)'(acc_q[c]) + RND;
      shaped[c] = rnd[c] >>> SHIFT;
      if (shaped[c] > Y_MAX) begin
        y_clip[c*DATA_W +: DATA_W] = Y_MAX[DATA_W-1:0];
        y_sat[c]                   = 1'b1;
      end else if (shaped[c] < Y_MIN) begin
        y_clip[c*DATA_W +: DATA_W] = Y_MIN[DATA_W-1:0];
        y_sat[c]                   = 1'b1;
      end else begin
        y_clip[c*DATA_W +: DATA_W] = shaped[c][DATA_W-1:0];
      end
    end
  end

  // Result registers only change on the edge that leaves DONE.
  always_comb begin
    smpl_out_d = smpl_out_q;
    sat_d      = sat_q;
    done_d     = publish;
    if (publish) begin
      smpl_out_d = y_clip;
      sat_d      = y_sat;
    end
  end

  // State, pipeline and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      coef_addr_q <= '0;
      smpl_rd_q   <= 1'b0;
      valid_d1_q  <= 1'b0;
      done_q      <= 1'b0;
      smpl_out_q  <= '0;
      sat_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      coef_addr_q <= coef_addr_d;
      smpl_rd_q   <= smpl_rd_d;
      valid_d1_q  <= smpl_rd_q;
      done_q      <= done_d;
      smpl_out_q  <= smpl_out_d;
      sat_q       <= sat_d;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign coef_addr = coef_addr_q;
  assign smpl_rd   = smpl_rd_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign smpl_out  = smpl_out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fir_mc_engine.sv
// Testbench for fir_mc_engine (NUM_TAPS=4, NUM_CH=2). Behavioural ROM and
// sample queue feed the DUT; a reference model computes each pass result from
// plain integer arithmetic and a monitor compares on every done pulse.
module tb_fir_mc_engine;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int NUM_TAPS = 4;
  localparam int NUM_CH   = 2;
  localparam int ACC_W    = 42;
  localparam int SHIFT    = 15;
  localparam int AW       = $clog2(NUM_TAPS);
  localparam int YW       = NUM_CH * DATA_W;
  localparam int EXP_W    = 32 + NUM_CH + YW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start, clr;
  logic [AW-1:0]     coef_addr;
  logic              smpl_rd;
  logic [COEF_W-1:0] coeff_in;
  logic [YW-1:0]     smpl_in;
  logic              busy, done;
  logic [YW-1:0]     smpl_out;
  logic [NUM_CH-1:0] sat;

  fir_mc_engine #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS),
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .coef_addr(coef_addr), .smpl_rd(smpl_rd), .coeff_in(coeff_in),
    .smpl_in(smpl_in), .busy(busy), .done(done),
    .smpl_out(smpl_out), .sat(sat)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rd_cnt   = 0;

  logic [COEF_W-1:0] coef_rom  [NUM_TAPS];
  logic [COEF_W-1:0] pass_coef [NUM_TAPS];
  logic [YW-1:0]     pass_smpl [NUM_TAPS];
  logic [YW-1:0]     smpl_fifo [$];
  logic [EXP_W-1:0]  exp_q     [$];
  logic [EXP_W-1:0]  pend;
  logic [YW-1:0]     last_y;
  logic [NUM_CH-1:0] last_sat;

  always @(posedge clk) cyc <= cyc + 1;

  // external ROM and sample queue: one-cycle read latency
  always @(posedge clk) begin
    coeff_in <= coef_rom[coef_addr];
    if (smpl_rd && smpl_fifo.size() > 0) smpl_in <= smpl_fifo.pop_front();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // reference model: sum of products, optional rounding, shift, clip
  function automatic logic [EXP_W-1:0] model(input int dcyc);
    logic [YW-1:0]     y;
    logic [NUM_CH-1:0] s;
    logic [DATA_W-1:0] sw;
    logic [COEF_W-1:0] cw;
    longint acc, hi, lo;
    hi = (64'sd1 <<< (DATA_W - 1)) - 1;
    lo = -hi - 1;
    y = '0;
    s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc = 0;
      for (int t = 0; t < NUM_TAPS; t++) begin
        sw = pass_smpl[t][c*DATA_W +: DATA_W];
        cw = pass_coef[t];
        acc += longint'($signed(sw)) * longint'($signed(cw));
      end
`ifdef FIR_MC_ROUND_EN
      acc += 64'sd1 <<< (SHIFT - 1);
`endif
      acc = acc >>> SHIFT;
      if (acc > hi) begin
        acc  = hi;
        s[c] = 1'b1;
      end else if (acc < lo) begin
        acc  = lo;
        s[c] = 1'b1;
      end
      y[c*DATA_W +: DATA_W] = acc[DATA_W-1:0];
    end
    return {32'(dcyc), s, y};
  endfunction

  // driver tasks
  task automatic fill_const(input logic [15:0] cf, input logic [15:0] s0, input logic [15:0] s1);
    for (int t = 0; t < NUM_TAPS; t++) begin
      pass_coef[t] = cf;
      pass_smpl[t] = {s1, s0};
    end
  endtask

  task automatic fill_rand();
    for (int t = 0; t < NUM_TAPS; t++) begin
      pass_coef[t] = 16'($urandom_range(0, 65535));
      pass_smpl[t] = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    end
  endtask

  // Assert start for one edge; expected result and done cycle go to the scoreboard.
  task automatic issue();
    smpl_fifo.delete();
    for (int t = 0; t < NUM_TAPS; t++) begin
      coef_rom[t] = pass_coef[t];
      smpl_fifo.push_back(pass_smpl[t]);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pend  = model(cyc + NUM_TAPS + 3);
    exp_q.push_back(pend);
  endtask

  // Returns at the negedge of the done cycle; records the published result.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_timeout", 64'(seen), 64'd1);
    last_y   = pend[YW-1:0];
    last_sat = pend[YW +: NUM_CH];
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
    end else begin
      if (smpl_rd) begin
        chk("coef_addr_seq", 64'(coef_addr), 64'(rd_cnt));
        rd_cnt++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          chk("smpl_out", 64'(smpl_out), 64'(e[YW-1:0]));
          chk("sat", 64'(sat), 64'(e[YW +: NUM_CH]));
          chk("done_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
        end
        chk("smpl_rd_count", 64'(rd_cnt), 64'(NUM_TAPS));
        rd_cnt = 0;
      end else if (!busy) begin
        rd_cnt = 0;
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_smpl_rd"}, 64'(smpl_rd), 64'd0);
    chk({tag, "_coef_addr"}, 64'(coef_addr), 64'd0);
    chk({tag, "_smpl_out"}, 64'(smpl_out), 64'd0);
    chk({tag, "_sat"}, 64'(sat), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    clr      = 1'b0;
    coeff_in = '0;
    smpl_in  = '0;
    last_y   = '0;
    last_sat = '0;
    for (int t = 0; t < NUM_TAPS; t++) coef_rom[t] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic pass
    fill_const(16'h4000, 16'h2000, 16'h2000);
    issue();
    wait_done();

    // saturation in both directions
    @(negedge clk);
    fill_const(16'h7FFF, 16'h7FFF, 16'h8000);
    issue();
    wait_done();

    // start pulses while busy are ignored
    @(negedge clk);
    fill_rand();
    issue();                          // sampled at edge 0
    @(posedge clk); #1; start = 1'b1; // sampled at edge 2
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1; start = 1'b1; // sampled at edge 5
    @(posedge clk); #1; start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    chk("busy_after_ignored_start", 64'(busy), 64'd0);

    // asynchronous reset at tap 2
    fill_const(16'h4000, 16'h2000, 16'h2000);
    issue();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    void'(exp_q.pop_back());
    last_y   = '0;
    last_sat = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_const(16'h4000, 16'h2000, 16'h2000);
    issue();
    wait_done();

    // clr at tap 2: back to IDLE, previous result held
    @(negedge clk);
    fill_rand();
    issue();
    repeat (2) @(posedge clk);
    #1; clr = 1'b1;
    @(posedge clk);
    #1; clr = 1'b0;
    void'(exp_q.pop_back());
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_smpl_rd", 64'(smpl_rd), 64'd0);
    chk("clr_smpl_out_held", 64'(smpl_out), 64'(last_y));
    chk("clr_sat_held", 64'(sat), 64'(last_sat));
    repeat (12) @(negedge clk);
    chk("clr_no_done_busy", 64'(busy), 64'd0);

    // clr has priority over start in IDLE
    clr = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; start = 1'b0;
    chk("clr_over_start", 64'(busy), 64'd0);
    @(negedge clk);

    // back-to-back passes: start in the done cycle
    fill_rand();
    issue();
    wait_done();
    fill_rand();
    issue();
    wait_done();

    // rounding behaviour
    @(negedge clk);
    fill_const(16'h0001, 16'h3000, 16'hD000);
    issue();
    wait_done();

    // randomized passes, mixing idle gaps and back-to-back starts
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      fill_rand();
      if ($urandom_range(0, 3) == 0) begin
        for (int t = 0; t < NUM_TAPS; t++) pass_coef[t] = 16'h7FFF;
      end
      issue();
      wait_done();
    end

    repeat (15) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
